// File: rtl/input_debouncer.sv
// Multi-channel switch/button debouncer: per-channel synchronizer, stability
// counter and accept FSM, with registered level, edge and any-change outputs.
module input_debouncer #(
    parameter int unsigned           NUM_INPUTS      = 8,
    parameter int unsigned           SYNC_STAGES     = 2,
    parameter int unsigned           DEBOUNCE_CYCLES = 12000,
    parameter logic [NUM_INPUTS-1:0] INIT_VALUE      = '0
) (
    input  logic                  clk_system_i,
    input  logic                  reset_n_i,
    input  logic [NUM_INPUTS-1:0] raw_i,
    input  logic                  clear_i,
    output logic [NUM_INPUTS-1:0] debounced_o,
    output logic [NUM_INPUTS-1:0] rise_o,
    output logic [NUM_INPUTS-1:0] fall_o,
    output logic                  changed_o
);

    localparam int unsigned        CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);

    typedef enum logic {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } ch_state_t;

    logic [NUM_INPUTS-1:0] sync_q [SYNC_STAGES];
    logic [NUM_INPUTS-1:0] sampled;
    logic [NUM_INPUTS-1:0] deb_q;
    logic [NUM_INPUTS-1:0] rise_q;
    logic [NUM_INPUTS-1:0] fall_q;
    logic [CNT_W-1:0]      cnt_q   [NUM_INPUTS];
    ch_state_t             state_q [NUM_INPUTS];

    always_ff @(posedge clk_system_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= INIT_VALUE;
            end
        end else begin
            sync_q[0] <= raw_i;
            for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign sampled = sync_q[SYNC_STAGES-1];

    // Edge pulses default low each cycle; an accept overrides its own bit.
    always_ff @(posedge clk_system_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            deb_q  <= INIT_VALUE;
            rise_q <= '0;
            fall_q <= '0;
            for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
                cnt_q[i]   <= '0;
                state_q[i] <= STABLE;
            end
        end else begin
            rise_q <= '0;
            fall_q <= '0;
            for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
                if (clear_i) begin
                    cnt_q[i]   <= '0;
                    state_q[i] <= STABLE;
                end else begin
                    case (state_q[i])
                        STABLE: begin
                            if (sampled[i] != deb_q[i]) begin
                                cnt_q[i]   <= CNT_ONE;
                                state_q[i] <= PENDING;
                            end
                        end
                        PENDING: begin
                            if (sampled[i] == deb_q[i]) begin
                                cnt_q[i]   <= '0;
                                state_q[i] <= STABLE;
                            end else if (cnt_q[i] == CNT_MAX) begin
                                deb_q[i]   <= sampled[i];
                                rise_q[i]  <= sampled[i];
                                fall_q[i]  <= ~sampled[i];
                                cnt_q[i]   <= '0;
                                state_q[i] <= STABLE;
                            end else begin
                                cnt_q[i] <= cnt_q[i] + CNT_ONE;
                            end
                        end
                        default: begin
                            cnt_q[i]   <= '0;
                            state_q[i] <= STABLE;
                        end
                    endcase
                end
            end
        end
    end

    assign debounced_o = deb_q;
    assign rise_o      = rise_q;
    assign fall_o      = fall_q;
    assign changed_o   = |(rise_q | fall_q);

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer (4 channels, 2 sync stages, 4-cycle window)
// with a per-cycle expected-output queue.
module tb_input_debouncer;

    logic       clk;
    logic       reset_n;
    logic [3:0] raw;
    logic       clear;
    logic [3:0] debounced;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       changed;

    int unsigned tests_run;
    int unsigned tests_failed;

    typedef struct {
        logic [3:0] deb;
        logic [3:0] rise;
        logic [3:0] fall;
        logic       chg;
        string      tag;
    } exp_t;

    exp_t sbq[$];

    input_debouncer #(
        .NUM_INPUTS      (4),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .INIT_VALUE      (4'b0000)
    ) dut (
        .clk_system_i (clk),
        .reset_n_i    (reset_n),
        .raw_i        (raw),
        .clear_i      (clear),
        .debounced_o  (debounced),
        .rise_o       (rise),
        .fall_o       (fall),
        .changed_o    (changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
        tests_run++;
        assert (obs === exp_v) else begin
            tests_failed++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
        end
    endtask

    task automatic push(input int unsigned n, input logic [3:0] deb, input logic [3:0] ri,
                        input logic [3:0] fa, input logic chg, input string tag);
        exp_t e;
        e.deb  = deb;
        e.rise = ri;
        e.fall = fa;
        e.chg  = chg;
        e.tag  = tag;
        for (int unsigned k = 0; k < n; k++) sbq.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sbq.size() == 0) begin
            tests_run++;
            tests_failed++;
            $error("FAIL sb_empty observed=empty expected=entry");
        end else begin
            e = sbq.pop_front();
            chk({e.tag, "_deb"},  debounced,     e.deb);
            chk({e.tag, "_rise"}, rise,          e.rise);
            chk({e.tag, "_fall"}, fall,          e.fall);
            chk({e.tag, "_chg"},  {3'b000, changed}, {3'b000, e.chg});
        end
    endtask

    task automatic run(input int unsigned n);
        for (int unsigned k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            pop_check();
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset_n      = 1'b0;
        raw          = 4'b0000;
        clear        = 1'b0;

        // Reset state
        #12;
        push(1, 4'b0000, 4'b0000, 4'b0000, 1'b0, "reset");
        pop_check();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        push(2, 4'b0000, 4'b0000, 4'b0000, 1'b0, "idle");
        run(2);

        // Single channel rise, accepted on 6th edge, then fall
        raw = 4'b0001;
        push(5, 4'b0000, 4'b0000, 4'b0000, 1'b0, "r0_wait");
        push(1, 4'b0001, 4'b0001, 4'b0000, 1'b1, "r0_acc");
        push(2, 4'b0001, 4'b0000, 4'b0000, 1'b0, "r0_hold");
        run(8);
        raw = 4'b0000;
        push(5, 4'b0001, 4'b0000, 4'b0000, 1'b0, "f0_wait");
        push(1, 4'b0000, 4'b0000, 4'b0001, 1'b1, "f0_acc");
        push(2, 4'b0000, 4'b0000, 4'b0000, 1'b0, "f0_hold");
        run(8);

        // Glitch one cycle short of the window
        raw = 4'b0010;
        push(3, 4'b0000, 4'b0000, 4'b0000, 1'b0, "g1_hi");
        run(3);
        raw = 4'b0000;
        push(8, 4'b0000, 4'b0000, 4'b0000, 1'b0, "g1_rej");
        run(8);

        // Pulse exactly the window length: accepted, then released
        raw = 4'b0100;
        push(4, 4'b0000, 4'b0000, 4'b0000, 1'b0, "x2_hi");
        run(4);
        raw = 4'b0000;
        push(1, 4'b0000, 4'b0000, 4'b0000, 1'b0, "x2_wait");
        push(1, 4'b0100, 4'b0100, 4'b0000, 1'b1, "x2_rise");
        push(3, 4'b0100, 4'b0000, 4'b0000, 1'b0, "x2_held");
        push(1, 4'b0000, 4'b0000, 4'b0100, 1'b1, "x2_fall");
        push(2, 4'b0000, 4'b0000, 4'b0000, 1'b0, "x2_idle");
        run(8);

        // All channels at once
        raw = 4'b1111;
        push(5, 4'b0000, 4'b0000, 4'b0000, 1'b0, "all_wait");
        push(1, 4'b1111, 4'b1111, 4'b0000, 1'b1, "all_rise");
        push(2, 4'b1111, 4'b0000, 4'b0000, 1'b0, "all_hold");
        run(8);
        raw = 4'b0000;
        push(5, 4'b1111, 4'b0000, 4'b0000, 1'b0, "all_fwait");
        push(1, 4'b0000, 4'b0000, 4'b1111, 1'b1, "all_fall");
        push(2, 4'b0000, 4'b0000, 4'b0000, 1'b0, "all_fhold");
        run(8);

        // Clear on the would-be 5th edge restarts the window
        raw = 4'b0001;
        push(4, 4'b0000, 4'b0000, 4'b0000, 1'b0, "clr_pre");
        run(4);
        clear = 1'b1;
        push(1, 4'b0000, 4'b0000, 4'b0000, 1'b0, "clr_edge");
        run(1);
        clear = 1'b0;
        push(3, 4'b0000, 4'b0000, 4'b0000, 1'b0, "clr_post");
        push(1, 4'b0001, 4'b0001, 4'b0000, 1'b1, "clr_acc");
        push(1, 4'b0001, 4'b0000, 4'b0000, 1'b0, "clr_hold");
        run(5);

        // Clear while stable-high leaves the level alone
        clear = 1'b1;
        push(1, 4'b0001, 4'b0000, 4'b0000, 1'b0, "clr_keep");
        run(1);
        clear = 1'b0;

        // Reset mid-pending with channel 0 already high
        raw = 4'b1001;
        push(3, 4'b0001, 4'b0000, 4'b0000, 1'b0, "rst_pend");
        run(3);
        reset_n = 1'b0;
        raw     = 4'b1000;
        #1;
        push(1, 4'b0000, 4'b0000, 4'b0000, 1'b0, "rst_async");
        pop_check();
        push(2, 4'b0000, 4'b0000, 4'b0000, 1'b0, "rst_hold");
        run(2);
        reset_n = 1'b1;
        push(5, 4'b0000, 4'b0000, 4'b0000, 1'b0, "rel_wait");
        push(1, 4'b1000, 4'b1000, 4'b0000, 1'b1, "rel_acc");
        push(2, 4'b1000, 4'b0000, 4'b0000, 1'b0, "rel_hold");
        run(8);

        tests_run++;
        assert (sbq.size() == 0) else begin
            tests_failed++;
            $error("FAIL sb_leftover observed=%0d expected=0", sbq.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/input_debouncer.md
INPUT_DEBOUNCER -- requirements
Module: input_debouncer

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 8, number of independent input channels (1..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer flop depth per channel (2..4).
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 12000 (1 ms at 12 MHz), stability window in clock cycles (2..2^20).
REQ-004 SHALL have parameter INIT_VALUE, default 0, NUM_INPUTS-bit reset level of synchronizers and debounced outputs.
REQ-005 SHALL have port clk_system_i, input, 1, system clock; the block uses one clock only.
REQ-006 SHALL have port reset_n_i, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port raw_i, input, NUM_INPUTS, asynchronous switch/button levels from pads.
REQ-008 SHALL have port clear_i, input, 1, synchronous clear of all stability counters.
REQ-009 SHALL have port debounced_o, output, NUM_INPUTS, filtered level per channel.
REQ-010 SHALL have port rise_o, output, NUM_INPUTS, one-cycle pulse on accepted 0->1.
REQ-011 SHALL have port fall_o, output, NUM_INPUTS, one-cycle pulse on accepted 1->0.
REQ-012 SHALL have port changed_o, output, 1, one-cycle pulse when any channel is accepted.

Function
REQ-013 SHALL pass each raw_i bit through SYNC_STAGES flops; the last stage is the sampled level s.
REQ-014 SHALL keep per channel an unsigned counter of width clog2(DEBOUNCE_CYCLES) and a state bit d driving debounced_o.
REQ-015 SHALL run per channel two states: STABLE (s==d, counter 0) and PENDING (s!=d, counter counting).
REQ-016 STABLE->PENDING when s!=d: counter becomes 1 on that edge.
REQ-017 In PENDING with s!=d and counter < DEBOUNCE_CYCLES-1: counter increments by 1.
REQ-018 In PENDING with s!=d and counter == DEBOUNCE_CYCLES-1: d<=s, counter<=0, return to STABLE.
REQ-019 In PENDING with s==d (glitch ended), including on the would-be accept edge: counter<=0, d unchanged, return to STABLE, no pulse.
REQ-020 Latency: a raw_i level change held stable SHALL change debounced_o on the (SYNC_STAGES+DEBOUNCE_CYCLES)-th rising edge after the change.
REQ-021 A level held at s for fewer than DEBOUNCE_CYCLES consecutive cycles SHALL never reach debounced_o.
REQ-022 rise_o[i]/fall_o[i] SHALL be registered and asserted for exactly the one cycle during which debounced_o[i] first shows its new value.
REQ-023 changed_o SHALL equal the OR of all rise_o and fall_o bits, in the same cycle.
REQ-024 Channels SHALL be fully independent; simultaneous accepts on several channels SHALL produce all pulses in the same cycle.
REQ-025 clear_i high SHALL force all counters to 0 and states to STABLE on that edge, leave debounced_o unchanged, and suppress any accept on that edge; clear_i has priority over REQ-018.
REQ-026 Counters SHALL never wrap; the maximum value reached is DEBOUNCE_CYCLES-1.

Reset
REQ-027 reset_n_i low SHALL asynchronously set synchronizers and debounced_o to INIT_VALUE, counters to 0, and rise_o, fall_o, changed_o to 0.
REQ-028 Reset asserted mid-PENDING SHALL discard the pending change; no pulse SHALL be produced on reset assertion or release.
REQ-029 After reset release, a raw_i differing from INIT_VALUE SHALL be accepted per REQ-020 with a normal rise/fall pulse.

Verification (NUM_INPUTS=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, INIT_VALUE=0)
REQ-030 raw_i[0] 0->1 held -> debounced_o[0]=1 on 6th edge; rise_o[0] and changed_o high for exactly that one cycle; other bits 0.
REQ-031 raw_i[1] high for 3 cycles then low -> debounced_o[1] stays 0; no pulses.
REQ-032 raw_i[2] high exactly 4 cycles -> accepted 1 on 6th edge, then fall accepted 4 cycles later with one fall_o[2] pulse.
REQ-033 raw_i=4'b1111 at once -> all bits accepted same edge, rise_o=4'b1111, changed_o single pulse.
REQ-034 clear_i pulsed on the 5th edge of a pending change -> no accept; change completes 4 cycles after clear if raw held.
REQ-035 reset_n_i low during PENDING -> outputs 0 immediately, no pulse; after release with raw_i[3]=1 held -> accepted on 6th edge.
